// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix multiplier array, its job sequencer and benches.
package matmul_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        READ,
        EMIT
    } seq_state_t;

    // Index width for an n-wide dimension; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_timeout_counter.sv
// Cycle counter guarding the wait for multiplier completion.
// expired rises on the TIMEOUT_CYCLES-th enabled cycle after clear and stays until cleared.
module matmul_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Count enabled cycles; flag one cycle early so expired is visible on the final counted cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(TIMEOUT_CYCLES - 2)) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_job_sequencer.sv
// Job sequencer for the parallel matrix multiplier: start pulse, guarded wait for a
// fresh done, then row-major streaming of the N x N result with backpressure.
// Optional build macro MATMUL_SEQ_PERF_EN adds a 32-bit busy-cycle counter on perf_cycles.
module matmul_job_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned N              = 4,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned IDX_W          = idx_width(N),
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              mul_start,
    input  logic              mul_done,
    output logic [IDX_W-1:0]  mul_z_i,
    output logic [IDX_W-1:0]  mul_z_j,
    input  logic [DATA_W-1:0] mul_z_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [IDX_W-1:0]  res_row,
    output logic [IDX_W-1:0]  res_col,
    output logic              res_last,
    output logic              busy,
    output logic              error
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    seq_state_t       state;
    logic [IDX_W-1:0] row_q;
    logic [IDX_W-1:0] col_q;
    logic             armed;
    logic             at_last_c;
    logic             tmo_clear_c;
    logic             tmo_enable_c;
    logic             tmo_expired;

    assign at_last_c    = (row_q == IDX_W'(N - 1)) && (col_q == IDX_W'(N - 1));
    assign tmo_clear_c  = (state == START);
    assign tmo_enable_c = (state == WAIT_DONE);

    // Read address into the array always follows the element counters.
    assign mul_z_i = row_q;
    assign mul_z_j = col_q;

    matmul_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmo_clear_c),
        .enable (tmo_enable_c),
        .expired(tmo_expired)
    );

    // Job FSM with registered handshake, status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            mul_start <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_row   <= '0;
            res_col   <= '0;
            res_last  <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            armed     <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        error     <= 1'b0;
                        row_q     <= '0;
                        col_q     <= '0;
                        mul_start <= 1'b1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    armed <= 1'b0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done left over from the previous job must drop before it counts.
                    if (!mul_done) begin
                        armed <= 1'b1;
                    end
                    if (armed && mul_done) begin
                        state <= READ;
                    end else if (tmo_expired) begin
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                READ: begin
                    res_data  <= mul_z_out;
                    res_row   <= row_q;
                    res_col   <= col_q;
                    res_last  <= at_last_c;
                    res_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (res_last) begin
                            row_q     <= '0;
                            col_q     <= '0;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            col_q <= col_q + IDX_W'(1);
                            if (col_q == IDX_W'(N - 1)) begin
                                row_q <= row_q + IDX_W'(1);
                            end
                            state <= READ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_cnt;

    // Saturating busy-cycle count; the total including the final cycle is published on the last handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (state == IDLE && cmd_valid && cmd_ready) begin
                perf_cnt <= '0;
            end else if (state != IDLE && perf_cnt != '1) begin
                perf_cnt <= perf_cnt + 32'd1;
            end
            if (state == EMIT && res_ready && res_last) begin
                perf_cycles <= (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Randomized self-checking bench for matmul_job_sequencer with a behavioural array model.
module tb_matmul_job_sequencer;

    localparam int unsigned N      = 4;
    localparam int unsigned NN     = N * N;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 2;
    localparam int          TMO    = 64;

    typedef struct {
        int          row;
        int          col;
        logic [31:0] data;
        bit          last;
    } elem_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              mul_start;
    logic              mul_done;
    logic [IDX_W-1:0]  mul_z_i;
    logic [IDX_W-1:0]  mul_z_j;
    logic [DATA_W-1:0] mul_z_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [IDX_W-1:0]  res_row;
    logic [IDX_W-1:0]  res_col;
    logic              res_last;
    logic              busy;
    logic              error;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    logic [DATA_W-1:0] r_mem [NN];

    int n_cmp = 0;
    int n_mis = 0;

    // Array model and monitor state
    int    cyc = 0;
    int    start_cyc = -100;
    int    n_starts = 0;
    int    drop_dly = 1;
    int    rise_dly = 10;
    bit    never_done = 1'b0;
    bit    done_lvl = 1'b0;
    int    busy_cnt = 0;
    int    first_valid_cyc = -1;
    int    last_hs_cyc = -1;
    int    hs_count = 0;
    int    ready_pct = 100;
    bit    stall_armed = 1'b0;
    int    stall_row = 1;
    int    stall_col = 0;
    int    stall_len = 5;
    int    stall_left = 0;
    bit    prev_hold = 1'b0;
    logic [DATA_W-1:0] p_data;
    logic [IDX_W-1:0]  p_row, p_col, p_zi, p_zj;
    logic              p_last;
    elem_t exp_q[$];

    always #5 clk = ~clk;

    assign mul_z_out = r_mem[int'(mul_z_i) * N + int'(mul_z_j)];

    matmul_job_sequencer #(
        .N(N),
        .DATA_W(DATA_W),
        .IDX_W(IDX_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .mul_start(mul_start),
        .mul_done(mul_done),
        .mul_z_i(mul_z_i),
        .mul_z_j(mul_z_j),
        .mul_z_out(mul_z_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_row(res_row),
        .res_col(res_col),
        .res_last(res_last),
        .busy(busy),
        .error(error)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample outputs at negedge, run the array model, drive res_ready, score handshakes.
    task automatic tick();
        elem_t e;
        @(negedge clk);
        cyc++;
        if (mul_start) begin
            n_starts++;
            start_cyc = cyc;
        end
        if (start_cyc >= 0) begin
            if (cyc - start_cyc == drop_dly) done_lvl = 1'b0;
            if (!never_done && cyc - start_cyc == rise_dly) done_lvl = 1'b1;
        end
        mul_done = done_lvl;
        if (busy) busy_cnt++;
        if (res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_hold) begin
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, p_data);
            check("hold_row", res_row, p_row);
            check("hold_col", res_col, p_col);
            check("hold_last", res_last, p_last);
            check("hold_zi", mul_z_i, p_zi);
            check("hold_zj", mul_z_j, p_zj);
        end
        if (stall_left == 0 && stall_armed && res_valid &&
            int'(res_row) == stall_row && int'(res_col) == stall_col) begin
            stall_armed = 1'b0;
            stall_left  = stall_len;
        end
        if (stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
        end else begin
            res_ready = ($urandom_range(99) < ready_pct);
        end
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_elem", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("res_data", res_data, e.data);
                check("res_row", res_row, e.row);
                check("res_col", res_col, e.col);
                check("res_last", res_last, e.last);
            end
            hs_count++;
            if (res_last) last_hs_cyc = cyc;
        end
        prev_hold = res_valid && !res_ready;
        p_data = res_data;
        p_row  = res_row;
        p_col  = res_col;
        p_last = res_last;
        p_zi   = mul_z_i;
        p_zj   = mul_z_j;
    endtask

    task automatic setup_job(input int drop, input int rise, input int pct, input bit stall);
        elem_t e;
        exp_q.delete();
        for (int i = 0; i < NN; i++) begin
            r_mem[i] = $urandom;
            e.row  = i / N;
            e.col  = i % N;
            e.data = r_mem[i];
            e.last = (i == NN - 1);
            exp_q.push_back(e);
        end
        drop_dly        = drop;
        rise_dly        = rise;
        never_done      = 1'b0;
        ready_pct       = pct;
        stall_armed     = stall;
        stall_left      = 0;
        n_starts        = 0;
        start_cyc       = -100;
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
        hs_count        = 0;
        busy_cnt        = 0;
    endtask

    // Raise cmd_valid and return one cycle after the accept; acc is the accept cycle or -1.
    task automatic do_accept(input bit hold, output int acc);
        int guard;
        acc = -1;
        guard = 0;
        cmd_valid = 1'b1;
        while (acc < 0 && guard < 20) begin
            if (cmd_ready) acc = cyc;
            tick();
            guard++;
        end
        if (!hold) cmd_valid = 1'b0;
        check("accept_seen", acc >= 0, 1);
        check("start_lat", start_cyc, acc + 1);
        check("err_clr", error, 0);
    endtask

    task automatic run_job(input int drop, input int rise, input int pct, input bit hold, input bit stall);
        int acc;
        int guard;
        setup_job(drop, rise, pct, stall);
        stall_row = 1;
        stall_col = 0;
        stall_len = 5;
        do_accept(hold, acc);
        guard = 0;
        while (hs_count < NN && guard < 600) begin
            tick();
            guard++;
        end
        check("job_count", hs_count, NN);
        cmd_valid = 1'b0;
        tick();
        check("busy_off", busy, 0);
        check("cmd_ready_back", cmd_ready, 1);
        check("last_hs_prev", last_hs_cyc, cyc - 1);
        check("one_start", n_starts, 1);
        check("first_valid", first_valid_cyc, start_cyc + rise + 2);
        check("queue_empty", exp_q.size(), 0);
        check("z_idle", {mul_z_i, mul_z_j}, 0);
        if (pct == 100 && !stall) check("throughput", last_hs_cyc, first_valid_cyc + 2 * (NN - 1));
`ifdef MATMUL_SEQ_PERF_EN
        check("perf_cycles", perf_cycles, busy_cnt);
`endif
    endtask

    task automatic run_timeout();
        int acc;
        int guard;
`ifdef MATMUL_SEQ_PERF_EN
        logic [31:0] perf_before;
        perf_before = perf_cycles;
`endif
        setup_job(1, 1000, 100, 1'b0);
        exp_q.delete();
        never_done = 1'b1;
        do_accept(1'b0, acc);
        guard = 0;
        while (cyc < start_cyc + TMO && guard < 200) begin
            tick();
            guard++;
        end
        check("tmo_busy_last", busy, 1);
        check("tmo_err_late", error, 0);
        tick();
        check("tmo_err", error, 1);
        check("tmo_idle", cmd_ready, 1);
        check("tmo_busy_off", busy, 0);
        for (int k = 0; k < 4; k++) tick();
        check("tmo_sticky", error, 1);
        check("tmo_no_res", first_valid_cyc < 0, 1);
        check("tmo_one_start", n_starts, 1);
`ifdef MATMUL_SEQ_PERF_EN
        check("tmo_perf_kept", perf_cycles, perf_before);
`endif
    endtask

    task automatic run_reset_mid();
        int acc;
        int guard;
        bit found;
        setup_job(1, 8, 100, 1'b1);
        stall_row = 1;
        stall_col = 3;
        stall_len = 1000;
        do_accept(1'b0, acc);
        found = 1'b0;
        guard = 0;
        while (!found && guard < 300) begin
            tick();
            guard++;
            found = res_valid && res_row == 2'd1 && res_col == 2'd3;
        end
        check("rst_reach_e7", found, 1);
        check("rst_prior_cnt", hs_count, 7);
        rst = 1'b1;
        prev_hold = 1'b0;
        tick();
        rst = 1'b0;
        stall_left = 0;
        stall_armed = 1'b0;
        exp_q.delete();
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_rowcol", {res_row, res_col, res_last}, 0);
        check("rst_start", mul_start, 0);
        check("rst_z", {mul_z_i, mul_z_j}, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_cmd_ready", cmd_ready, 1);
`ifdef MATMUL_SEQ_PERF_EN
        check("rst_perf", perf_cycles, 0);
`endif
    endtask

    initial begin
        int d;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        mul_done  = 1'b0;
        tick();
        tick();
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_valid", res_valid, 0);
        check("reset_start", mul_start, 0);
        check("reset_error", error, 0);
        check("reset_z", {mul_z_i, mul_z_j}, 0);
        rst = 1'b0;
        tick();

        run_job(1, 10, 100, 1'b0, 1'b0);
        run_job(1, 6, 100, 1'b0, 1'b1);
        done_lvl = 1'b1;
        mul_done = 1'b1;
        tick();
        run_job(2, 20, 100, 1'b0, 1'b0);
        run_timeout();
        run_job(1, 5, 100, 1'b0, 1'b0);
        run_reset_mid();
        run_job(1, 9, 100, 1'b0, 1'b0);
        run_job(1, 7, 100, 1'b1, 1'b0);
        run_job(1, 4, 100, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            d = $urandom_range(2, 1);
            run_job(d, $urandom_range(30, d + 1), $urandom_range(100, 30), 1'b0, j[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
